// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    // Stage indices for the classic 5-stage configuration.
    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    typedef enum logic [0:0] {
        IDLE,
        PENDING
    } redirect_state_e;

    // Highest set bit of vec (0 if none set); supports up to 32 stages.
    function automatic int unsigned oldest_index(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Control bundle between the pipeline datapath and the hazard controller.
interface pipeline_hazard_controller_if #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned SEL_W  = $clog2(STAGES)
);
    logic [STAGES-1:0] requireStall;
    logic [STAGES-1:0] redirectReq;
    logic              flushAll;
    logic              clearTimeout;
    logic [STAGES-1:0] regStall;
    logic [STAGES-1:0] regFlush;
    logic              pcRedirect;
    logic [SEL_W-1:0]  redirectSel;
    logic              excRedirect;
    logic              redirectPending;
    logic              stallTimeout;

    // Datapath side: raises requests, consumes stall/flush/redirect controls.
    modport master (
        output requireStall, redirectReq, flushAll, clearTimeout,
        input  regStall, regFlush, pcRedirect, redirectSel, excRedirect,
               redirectPending, stallTimeout
    );

    // Controller side.
    modport slave (
        input  requireStall, redirectReq, flushAll, clearTimeout,
        output regStall, regFlush, pcRedirect, redirectSel, excRedirect,
               redirectPending, stallTimeout
    );
endinterface

// File: rtl/stall_watchdog.sv
// Counts consecutive PC-stall cycles and raises a sticky timeout flag.
module stall_watchdog #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clear,
    output logic timeout
);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntTrip = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic             flag_q;

    // Saturating stall counter; sticky flag where a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            if (stall) begin
                if (count_q != CntMax) begin
                    count_q <= count_q + 1'b1;
                end
            end else begin
                count_q <= '0;
            end
            if (stall && (count_q == CntTrip)) begin
                flag_q <= 1'b1;
            end else if (clear) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign timeout = flag_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/redirect controller for an N-stage in-order pipeline.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned STAGES  = 5,
    parameter int unsigned SEL_W   = $clog2(STAGES),
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT) + 1
) (
    input logic                          clk,
    input logic                          rst_n,
    pipeline_hazard_controller_if.slave  bus
);
    redirect_state_e   state_q;
    logic [SEL_W-1:0]  pend_sel_q;

    logic [STAGES-1:0] base_stall;
    logic [STAGES-1:0] base_flush;
    logic              live_v;
    logic [SEL_W-1:0]  live_k;
    logic              cand_v;
    logic [SEL_W-1:0]  cand_k;
    logic              accept;
    logic [STAGES-1:0] stall_out;
    logic [STAGES-1:0] flush_out;
    logic              pc_redirect;
    logic [SEL_W-1:0]  sel_out;
    logic              wd_stall;

    // Base rule: a stall holds every younger register; the stalled stage leaves a bubble.
    always_comb begin
        logic acc;
        acc        = 1'b0;
        base_stall = '0;
        base_flush = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            acc           = acc | bus.requireStall[i];
            base_stall[i] = acc;
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            base_flush[i] = bus.requireStall[i-1] & ~base_stall[i];
        end
    end

    assign live_v = |bus.redirectReq;
    assign live_k = SEL_W'(oldest_index(32'(bus.redirectReq)));

    // Pick the oldest redirect; a live pulse younger than the pending one is wrong-path.
    always_comb begin
        cand_v = live_v;
        cand_k = live_k;
        if (state_q == PENDING) begin
            cand_v = 1'b1;
            if (!live_v || (live_k <= pend_sel_q)) begin
                cand_k = pend_sel_q;
            end
        end
    end

    assign accept = cand_v & ~base_stall[cand_k] & ~bus.flushAll;

    // Output controls: exception flush first, then an accepted redirect, else base rule.
    always_comb begin
        stall_out   = base_stall;
        flush_out   = base_flush;
        pc_redirect = 1'b0;
        sel_out     = '0;
        if (bus.flushAll) begin
            stall_out = '0;
            flush_out = {{(STAGES-1){1'b1}}, 1'b0};
        end else if (accept) begin
            pc_redirect = 1'b1;
            sel_out     = cand_k;
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (i <= 32'(cand_k)) begin
                    stall_out[i] = 1'b0;
                    if (i >= 1) begin
                        flush_out[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Redirect FSM: latch an unaccepted redirect until it can be applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_sel_q <= '0;
        end else if (bus.flushAll || accept) begin
            state_q <= IDLE;
        end else if (cand_v) begin
            state_q    <= PENDING;
            pend_sel_q <= cand_k;
        end
    end

    assign wd_stall = stall_out[0] & ~pc_redirect & ~bus.flushAll;

    stall_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (wd_stall),
        .clear   (bus.clearTimeout),
        .timeout (bus.stallTimeout)
    );

    assign bus.regStall        = stall_out;
    assign bus.regFlush        = flush_out;
    assign bus.pcRedirect      = pc_redirect;
    assign bus.redirectSel     = sel_out;
    assign bus.excRedirect     = bus.flushAll;
    assign bus.redirectPending = (state_q == PENDING);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (STAGES=5, TIMEOUT=8).
module tb_pipeline_hazard_controller;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    pipeline_hazard_controller_if #(.STAGES(5), .SEL_W(3)) bus ();

    pipeline_hazard_controller #(
        .STAGES  (5),
        .SEL_W   (3),
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rr, input logic fa,
                         input logic ct);
        bus.requireStall = rs;
        bus.redirectReq  = rr;
        bus.flushAll     = fa;
        bus.clearTimeout = ct;
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        #3;
        chk("rst_regStall", 32'(bus.regStall), 32'd0);
        chk("rst_regFlush", 32'(bus.regFlush), 32'd0);
        chk("rst_pcRedirect", 32'(bus.pcRedirect), 32'd0);
        chk("rst_excRedirect", 32'(bus.excRedirect), 32'd0);
        chk("rst_pending", 32'(bus.redirectPending), 32'd0);
        chk("rst_timeout", 32'(bus.stallTimeout), 32'd0);
        #9;
        rst_n = 1'b1;
        tick();

        // EX stall
        drive(5'b00100, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("ex_regStall", 32'(bus.regStall), 32'b00111);
        chk("ex_regFlush", 32'(bus.regFlush), 32'b01000);
        chk("ex_pcRedirect", 32'(bus.pcRedirect), 32'd0);
        tick();

        // Immediate redirect from EX
        drive(5'b00000, 5'b00100, 1'b0, 1'b0);
        #2;
        chk("rd_pcRedirect", 32'(bus.pcRedirect), 32'd1);
        chk("rd_sel", 32'(bus.redirectSel), 32'd2);
        chk("rd_regFlush", 32'(bus.regFlush), 32'b00110);
        chk("rd_regStall", 32'(bus.regStall), 32'd0);
        tick();
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("rd_pending_after", 32'(bus.redirectPending), 32'd0);
        tick();

        // Redirect from EX blocked by a 3-cycle MEM stall
        drive(5'b01000, 5'b00100, 1'b0, 1'b0);
        #2;
        chk("blk_pcRedirect", 32'(bus.pcRedirect), 32'd0);
        chk("blk_regStall", 32'(bus.regStall), 32'b01111);
        chk("blk_regFlush", 32'(bus.regFlush), 32'b10000);
        chk("blk_pending0", 32'(bus.redirectPending), 32'd0);
        tick();
        drive(5'b01000, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("blk_pending1", 32'(bus.redirectPending), 32'd1);
        chk("blk_pc1", 32'(bus.pcRedirect), 32'd0);
        tick();
        #2;
        chk("blk_pending2", 32'(bus.redirectPending), 32'd1);
        chk("blk_pc2", 32'(bus.pcRedirect), 32'd0);
        tick();
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("blk_pending3", 32'(bus.redirectPending), 32'd1);
        chk("blk_release_pc", 32'(bus.pcRedirect), 32'd1);
        chk("blk_release_sel", 32'(bus.redirectSel), 32'd2);
        chk("blk_release_flush", 32'(bus.regFlush), 32'b00110);
        tick();
        #2;
        chk("blk_pending_clr", 32'(bus.redirectPending), 32'd0);
        tick();

        // Pending ID redirect overtaken by an older MEM redirect; later ID pulse ignored
        drive(5'b00010, 5'b00010, 1'b0, 1'b0);
        #2;
        chk("ovt_pc0", 32'(bus.pcRedirect), 32'd0);
        tick();
        drive(5'b10000, 5'b01000, 1'b0, 1'b0);
        #2;
        chk("ovt_pending", 32'(bus.redirectPending), 32'd1);
        chk("ovt_pc1", 32'(bus.pcRedirect), 32'd0);
        tick();
        drive(5'b10000, 5'b00010, 1'b0, 1'b0);
        #2;
        chk("ovt_pc2", 32'(bus.pcRedirect), 32'd0);
        chk("ovt_regStall", 32'(bus.regStall), 32'b11111);
        chk("ovt_regFlush", 32'(bus.regFlush), 32'd0);
        tick();
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("ovt_release_pc", 32'(bus.pcRedirect), 32'd1);
        chk("ovt_release_sel", 32'(bus.redirectSel), 32'd3);
        chk("ovt_release_flush", 32'(bus.regFlush), 32'b01110);
        chk("ovt_release_stall", 32'(bus.regStall), 32'd0);
        tick();
        #2;
        chk("ovt_pending_clr", 32'(bus.redirectPending), 32'd0);
        tick();

        // Exception flush overrides a pending redirect and a live pulse
        drive(5'b01000, 5'b00100, 1'b0, 1'b0);
        tick();
        drive(5'b01000, 5'b00010, 1'b1, 1'b0);
        #2;
        chk("exc_pending_before", 32'(bus.redirectPending), 32'd1);
        chk("exc_regFlush", 32'(bus.regFlush), 32'b11110);
        chk("exc_regStall", 32'(bus.regStall), 32'd0);
        chk("exc_excRedirect", 32'(bus.excRedirect), 32'd1);
        chk("exc_pcRedirect", 32'(bus.pcRedirect), 32'd0);
        tick();
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("exc_pending_after", 32'(bus.redirectPending), 32'd0);
        chk("exc_no_late_redirect", 32'(bus.pcRedirect), 32'd0);
        chk("exc_exc_clr", 32'(bus.excRedirect), 32'd0);
        tick();

        // Watchdog: WB stall held 10 cycles, flag visible from the 9th
        drive(5'b10000, 5'b00000, 1'b0, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            #2;
            chk($sformatf("wd_rise_c%0d", n), 32'(bus.stallTimeout),
                (n >= 9) ? 32'd1 : 32'd0);
            tick();
        end
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("wd_hold1", 32'(bus.stallTimeout), 32'd1);
        tick();
        #2;
        chk("wd_hold2", 32'(bus.stallTimeout), 32'd1);
        tick();
        drive(5'b00000, 5'b00000, 1'b0, 1'b1);
        #2;
        chk("wd_clear_same", 32'(bus.stallTimeout), 32'd1);
        tick();
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        #2;
        chk("wd_cleared", 32'(bus.stallTimeout), 32'd0);
        tick();

        // Reset in the middle of a long stall clears count and flag at once
        drive(5'b10000, 5'b00000, 1'b0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            tick();
        end
        #2;
        chk("wdr_set", 32'(bus.stallTimeout), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("wdr_async_flag", 32'(bus.stallTimeout), 32'd0);
        chk("wdr_regStall", 32'(bus.regStall), 32'b11111);
        tick();
        rst_n = 1'b1;
        for (int m = 1; m <= 9; m++) begin
            #2;
            chk($sformatf("wdr_recount_c%0d", m), 32'(bus.stallTimeout),
                (m >= 9) ? 32'd1 : 32'd0);
            tick();
        end
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
